j1_wb_uart: RTL and testbench



---
 rtl/j1_wb_uart_if.sv | 16 +
 rtl/j1_wb_uart.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_j1_wb_uart.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/j1_wb_uart_if.sv
// Wishbone bus bundle between the J1 master and its slaves.
// dat_m carries master write data, dat_s carries slave read data.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        ack;

  modport master (output cyc, output stb, output we, output adr, output dat_m,
                  input dat_s, input ack);
  modport slave  (input cyc, input stb, input we, input adr, input dat_m,
                  output dat_s, output ack);
endinterface

// File: rtl/j1_wb_uart.sv
// Wishbone slave 8N1 UART: TX FIFO, RX storage, sticky error flags and a level interrupt.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO; otherwise RX uses one holding register.
module j1_wb_uart #(
  parameter int unsigned CLK_DIV    = 217,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  if_wb.slave  wb,
  input  logic rxd,
  output logic txd,
  output logic irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [15:0] DivFull = 16'(CLK_DIV - 1);
  localparam logic [15:0] DivHalf = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {StTxIdle, StTxStart, StTxData, StTxStop} tx_state_e;
  typedef enum logic [2:0] {StRxIdle, StRxStart, StRxData, StRxStop, StRxBreak} rx_state_e;

  // Bus decode; every side effect lands on the edge that raises ack.
  logic access, rd_data, rd_status, wr_data, wr_ctrl;
  logic ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;

  assign access    = wb.cyc & wb.stb & ~ack_q;
  assign rd_data   = access & ~wb.we & (wb.adr[1:0] == 2'd0);
  assign rd_status = access & ~wb.we & (wb.adr[1:0] == 2'd1);
  assign wr_data   = access &  wb.we & (wb.adr[1:0] == 2'd0);
  assign wr_ctrl   = access &  wb.we & (wb.adr[1:0] == 2'd2);
  assign ack_d     = access;

  logic unused_bits;
  assign unused_bits = ^{wb.adr[15:2], wb.dat_m[15:8]};

  logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, tx_drop_q, tx_drop_d;
  logic irq_q, irq_d;

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_full, tx_empty, tx_push, tx_pop, tx_idle;
  logic [7:0]      tx_head;

  assign tx_full  = (tx_cnt_q == DepthCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rptr_q];
  assign tx_push  = wr_data & ~tx_full;

  always_comb begin
    tx_wptr_d = tx_wptr_q + PtrW'(tx_push);
    tx_rptr_d = tx_rptr_q + PtrW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wb.dat_m[7:0];
  end

  // ---------------- TX shifter ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  assign tx_idle = tx_empty & (tx_state_q == StTxIdle);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      StTxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_div_d   = DivFull;
          tx_state_d = StTxStart;
        end
      end
      StTxStart: begin
        if (tx_div_q == '0) begin
          tx_div_d   = DivFull;
          tx_bit_d   = 3'd0;
          tx_state_d = StTxData;
        end else begin
          tx_div_d = tx_div_q - 16'd1;
        end
      end
      StTxData: begin
        if (tx_div_q == '0) begin
          tx_div_d   = DivFull;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = StTxStop;
        end else begin
          tx_div_d = tx_div_q - 16'd1;
        end
      end
      StTxStop: begin
        if (tx_div_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_div_d   = DivFull;
            tx_state_d = StTxStart;
          end else begin
            tx_state_d = StTxIdle;
          end
        end else begin
          tx_div_d = tx_div_q - 16'd1;
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      StTxStart: txd_d = 1'b0;
      StTxData:  txd_d = tx_shift_q[0];
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;

  // ---------------- RX sampler ----------------
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d, rxd_s, rx_fall;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_push, frame_set;

  assign rx_sync_d = {rx_sync_q[0], rxd};
  assign rxd_s     = rx_sync_q[1];
  assign rx_prev_d = rxd_s;
  assign rx_fall   = rx_prev_q & ~rxd_s;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      StRxIdle: begin
        if (rx_fall) begin
          rx_div_d   = DivHalf;
          rx_state_d = StRxStart;
        end
      end
      StRxStart: begin
        if (rx_div_q == '0) begin
          if (rxd_s) begin
            rx_state_d = StRxIdle;
          end else begin
            rx_div_d   = DivFull;
            rx_bit_d   = 3'd0;
            rx_state_d = StRxData;
          end
        end else begin
          rx_div_d = rx_div_q - 16'd1;
        end
      end
      StRxData: begin
        if (rx_div_q == '0) begin
          rx_div_d   = DivFull;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = StRxStop;
        end else begin
          rx_div_d = rx_div_q - 16'd1;
        end
      end
      StRxStop: begin
        if (rx_div_q == '0) begin
          if (rxd_s) begin
            rx_push    = 1'b1;
            rx_state_d = StRxIdle;
          end else begin
            frame_set  = 1'b1;
            rx_state_d = StRxBreak;
          end
        end else begin
          rx_div_d = rx_div_q - 16'd1;
        end
      end
      StRxBreak: begin
        if (rxd_s) rx_state_d = StRxIdle;
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  // ---------------- RX storage ----------------
  logic       rx_valid, rx_pop, rx_accept, rx_ovr_set;
  logic [7:0] rx_head;

  assign rx_pop     = rd_data & rx_valid;
  assign rx_ovr_set = rx_push & ~rx_accept;

`ifdef UART_RX_FIFO_EN
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_full;

  assign rx_full   = (rx_cnt_q == DepthCnt);
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_head   = rx_mem_q[rx_rptr_q];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_accept = rx_push & (~rx_full | rx_pop);

  always_comb begin
    rx_wptr_d = rx_wptr_q + PtrW'(rx_accept);
    rx_rptr_d = rx_rptr_q + PtrW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + CntW'(rx_accept) - CntW'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end
`else
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rx_full_q, rx_full_d;

  assign rx_valid  = rx_full_q;
  assign rx_head   = rx_hold_q;
  assign rx_accept = rx_push & (~rx_full_q | rx_pop);

  always_comb begin
    rx_full_d = rx_accept | (rx_full_q & ~rx_pop);
    rx_hold_d = rx_accept ? rx_shift_q : rx_hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end
`endif

  // ---------------- Registers, flags, read mux ----------------
  always_comb begin
    rx_ie_d     = wr_ctrl ? wb.dat_m[0] : rx_ie_q;
    tx_ie_d     = wr_ctrl ? wb.dat_m[1] : tx_ie_q;
    // Set wins over the read-clear so a coincident event is not lost.
    rx_ovr_d    = (rx_ovr_q & ~rd_status) | rx_ovr_set;
    frame_err_d = (frame_err_q & ~rd_status) | frame_set;
    tx_drop_d   = (tx_drop_q & ~rd_status) | (wr_data & tx_full);
    irq_d       = (rx_ie_q & rx_valid) | (tx_ie_q & tx_idle);
  end

  always_comb begin
    rdata_d = 16'h0000;
    if (access && !wb.we) begin
      case (wb.adr[1:0])
        2'd0:    rdata_d = rx_valid ? {8'h00, rx_head} : 16'h0000;
        2'd1:    rdata_d = {10'h000, tx_drop_q, frame_err_q, rx_ovr_q, tx_idle, tx_full, rx_valid};
        2'd2:    rdata_d = {14'h0000, tx_ie_q, rx_ie_q};
        default: rdata_d = 16'h0000;
      endcase
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_s = rdata_q;
  assign irq      = irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_drop_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
      tx_drop_q   <= tx_drop_d;
      irq_q       <= irq_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= StTxIdle;
      tx_div_q   <= 16'h0000;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StRxIdle;
      rx_div_q   <= 16'h0000;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_j1_wb_uart.sv
// Directed bench for j1_wb_uart at CLK_DIV=8, FIFO_DEPTH=4; a side process decodes txd frames.
module tb_j1_wb_uart;
  localparam int unsigned ClkDiv    = 8;
  localparam int unsigned FifoDepth = 4;

  logic clk, reset, rxd, txd, irq;
  if_wb wb_bus ();

  j1_wb_uart #(.CLK_DIV(ClkDiv), .FIFO_DEPTH(FifoDepth)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_bus),
    .rxd   (rxd),
    .txd   (txd),
    .irq   (irq)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  tx_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                          output logic [15:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = 16'h0000;
    wb_bus.cyc   = 1'b1;
    wb_bus.stb   = 1'b1;
    wb_bus.we    = we;
    wb_bus.adr   = adr;
    wb_bus.dat_m = wdat;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_bus.ack === 1'b1) begin
        rdat = wb_bus.dat_s;
        got  = 1'b1;
        break;
      end
    end
    wb_bus.cyc = 1'b0;
    wb_bus.stb = 1'b0;
    wb_bus.we  = 1'b0;
    chk("bus ack", {15'h0000, got}, 16'h0001);
  endtask

  task automatic wr(input logic [15:0] adr, input logic [15:0] dat);
    logic [15:0] d;
    bus_xfer(1'b1, adr, dat, d);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] adr, input logic [15:0] exp);
    logic [15:0] d;
    bus_xfer(1'b0, adr, 16'h0000, d);
    chk(tag, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (ClkDiv) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (ClkDiv) tick();
    end
    rxd = stop;
    repeat (ClkDiv) tick();
    rxd = 1'b1;
  endtask

  // Reference 8N1 receiver on txd, sampling at mid-bit.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (ClkDiv / 2) tick();
      for (int i = 0; i < 8; i++) begin
        repeat (ClkDiv) tick();
        b[i] = txd;
      end
      repeat (ClkDiv) tick();
      tx_q.push_back(b);
    end
  end

  initial begin : main
    logic [7:0] exp_a5;
    logic [7:0] rx_bytes [5];
    int         n_keep;

    exp_a5   = 8'hA5;
    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`ifdef UART_RX_FIFO_EN
    n_keep = 4;
`else
    n_keep = 1;
`endif

    reset = 1'b1;
    rxd   = 1'b1;
    wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
    wb_bus.adr = 16'h0000; wb_bus.dat_m = 16'h0000;
    repeat (3) tick();
    chk("reset txd", {15'h0, txd}, 16'h0001);
    chk("reset irq", {15'h0, irq}, 16'h0000);
    chk("reset ack", {15'h0, wb_bus.ack}, 16'h0000);
    chk("reset rdata", wb_bus.dat_s, 16'h0000);
    reset = 1'b0;
    tick();
    rd_chk("reset status", 16'h0001, 16'h0004);
    rd_chk("reset ctrl", 16'h0002, 16'h0000);

    // TX of 0xA5: start bit two cycles after ack, then LSB first.
    wr(16'h0000, 16'h00A5);
    tick();
    chk("tx before start", {15'h0, txd}, 16'h0001);
    tick();
    chk("tx start edge", {15'h0, txd}, 16'h0000);
    repeat (ClkDiv / 2) tick();
    chk("tx start mid", {15'h0, txd}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      repeat (ClkDiv) tick();
      chk($sformatf("tx a5 bit%0d", i), {15'h0, txd}, {15'h0, exp_a5[i]});
    end
    repeat (ClkDiv) tick();
    chk("tx stop", {15'h0, txd}, 16'h0001);
    repeat (4) tick();
    rd_chk("tx idle status", 16'h0001, 16'h0004);

    // RX of 0x3C.
    send_rx(8'h3C, 1'b1);
    repeat (6) tick();
    rd_chk("rx valid status", 16'h0001, 16'h0005);
    rd_chk("rx data 3c", 16'h0000, 16'h003C);
    rd_chk("rx after pop", 16'h0001, 16'h0004);

    // RX interrupt follows rx_valid.
    wr(16'h0002, 16'h0001);
    send_rx(8'h81, 1'b1);
    repeat (6) tick();
    chk("rx irq set", {15'h0, irq}, 16'h0001);
    rd_chk("rx data 81", 16'h0000, 16'h0081);
    tick();
    tick();
    chk("rx irq clear", {15'h0, irq}, 16'h0000);
    wr(16'h0002, 16'h0000);

    // Overrun: five bytes with no reads.
    for (int i = 0; i < 5; i++) send_rx(rx_bytes[i], 1'b1);
    repeat (6) tick();
    rd_chk("overrun status", 16'h0001, 16'h000D);
    rd_chk("overrun cleared", 16'h0001, 16'h0005);
    for (int i = 0; i < n_keep; i++) rd_chk($sformatf("rx keep %0d", i), 16'h0000, {8'h00, rx_bytes[i]});
    rd_chk("rx drained status", 16'h0001, 16'h0004);
    rd_chk("rx empty read", 16'h0000, 16'h0000);

    // Framing error: 0x55 with a low stop bit.
    send_rx(8'h55, 1'b0);
    repeat (6) tick();
    rd_chk("frame err status", 16'h0001, 16'h0014);
    rd_chk("frame err cleared", 16'h0001, 16'h0004);

    // Six writes back-to-back: one in the shifter, four queued, one dropped.
    tx_q.delete();
    for (int i = 1; i <= 6; i++) wr(16'h0000, 16'(i));
    rd_chk("tx full drop status", 16'h0001, 16'h0022);
    repeat (430) tick();
    chk("tx frame count", 16'(tx_q.size()), 16'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("tx byte %0d", i), {8'h00, tx_q[i]}, 16'(i + 1));
    rd_chk("tx drained status", 16'h0001, 16'h0004);

    // TX interrupt and CTRL/reg3 decoding.
    chk("irq before tx_ie", {15'h0, irq}, 16'h0000);
    wr(16'h0002, 16'h0002);
    tick();
    tick();
    chk("irq tx idle", {15'h0, irq}, 16'h0001);
    rd_chk("ctrl readback", 16'h0002, 16'h0002);
    wr(16'h0003, 16'hFFFF);
    rd_chk("reg3 read", 16'h0003, 16'h0000);
    wr(16'h0002, 16'hFFFF);
    rd_chk("ctrl masked", 16'h0002, 16'h0003);
    wr(16'h0000, 16'h000F);
    tick();
    tick();
    chk("irq tx busy", {15'h0, irq}, 16'h0000);
    repeat (90) tick();
    chk("irq tx done", {15'h0, irq}, 16'h0001);

    // Asynchronous reset in the middle of a frame.
    wr(16'h0000, 16'h0000);
    repeat (4) tick();
    chk("pre reset txd", {15'h0, txd}, 16'h0000);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset txd", {15'h0, txd}, 16'h0001);
    chk("async reset irq", {15'h0, irq}, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    rd_chk("post reset status", 16'h0001, 16'h0004);
    rd_chk("post reset ctrl", 16'h0002, 16'h0000);
    repeat (10) tick();
    chk("post reset txd", {15'h0, txd}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
